// File: rtl/failure_logger_if.sv
// Bundles the logger's control, error-report, readout and status signals.
// master drives control/error/read-request; slave (the logger) returns readout and status.
interface failure_logger_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic              clear;
    logic              arm;
    logic              error_1;
    logic [ADDR_W-1:0] error_address_1;
    logic              error_2;
    logic [ADDR_W-1:0] error_address_2;
    logic              rd_req;
    logic              rd_valid;
    logic              rd_channel;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_empty;
    logic [CNT_W-1:0]  fail_count_1;
    logic [CNT_W-1:0]  fail_count_2;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;
    logic              logging;

    modport master (
        output clear, arm, error_1, error_address_1, error_2, error_address_2, rd_req,
        input  rd_valid, rd_channel, rd_address, rd_empty,
        input  fail_count_1, fail_count_2, drop_count, overflow, logging
    );

    modport slave (
        input  clear, arm, error_1, error_address_1, error_2, error_address_2, rd_req,
        output rd_valid, rd_channel, rd_address, rd_empty,
        output fail_count_1, fail_count_2, drop_count, overflow, logging
    );
endinterface

// File: rtl/failure_logger.sv
// Counts RAM-test failures per channel and queues {channel,address} in a DEPTH-entry FIFO.
// Pop data appears one cycle after rd_req; a full FIFO drops new events (counted, sticky overflow).
module failure_logger #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int HOLDOFF = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    failure_logger_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int HW    = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {IDLE, HOLD, ARMED} state_t;
    typedef logic [ADDR_W:0] entry_t;

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fail_cnt_1;
    logic [CNT_W-1:0]  fail_cnt_2;
    logic [CNT_W-1:0]  drop_cnt;
    logic              ovf;
    logic              rd_vld;
    logic              rd_ch;
    logic [ADDR_W-1:0] rd_addr;
    logic              logging_q;
    entry_t            mem [DEPTH];

    logic [PTR_W-1:0]  occ;
    logic [PTR_W-1:0]  free;
    logic [PTR_W-1:0]  n_wr;
    logic [AW-1:0]     wr_idx0;
    logic [AW-1:0]     wr_idx1;
    logic              log_en;
    logic              want_1;
    logic              want_2;
    logic              pop;
    logic              wr0_en;
    logic              wr1_en;
    entry_t            wr0_dat;
    entry_t            wr1_dat;
    entry_t            head;
    logic [1:0]        n_drop;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Free space is taken from occupancy at the start of the cycle, so a same-cycle pop frees nothing.
    assign occ     = wr_ptr - rd_ptr;
    assign free    = PTR_W'(DEPTH) - occ;
    assign log_en  = (state == ARMED) && bus.arm && !bus.clear;
    assign want_1  = log_en && bus.error_1;
    assign want_2  = log_en && bus.error_2;
    assign pop     = bus.rd_req && (occ != '0) && !bus.clear;
    assign wr_idx0 = wr_ptr[AW-1:0];
    assign wr_idx1 = wr_ptr[AW-1:0] + AW'(1);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign n_wr    = PTR_W'(wr0_en) + PTR_W'(wr1_en);

    // Channel 1 always takes the first free slot; channel 2 only gets a slot left over.
    always_comb begin
        wr0_en  = 1'b0;
        wr1_en  = 1'b0;
        wr0_dat = {1'b0, bus.error_address_1};
        wr1_dat = {1'b1, bus.error_address_2};
        n_drop  = 2'd0;
        if (want_1 && want_2) begin
            if (free >= PTR_W'(2)) begin
                wr0_en = 1'b1;
                wr1_en = 1'b1;
            end else if (free == PTR_W'(1)) begin
                wr0_en = 1'b1;
                n_drop = 2'd1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (want_1 || want_2) begin
            if (want_2) wr0_dat = {1'b1, bus.error_address_2};
            if (free != '0) wr0_en = 1'b1;
            else            n_drop = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_idx0] <= wr0_dat;
        if (wr1_en) mem[wr_idx1] <= wr1_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            logging_q  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fail_cnt_1 <= '0;
            fail_cnt_2 <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
            rd_vld     <= 1'b0;
            rd_ch      <= 1'b0;
            rd_addr    <= '0;
        end else if (bus.clear) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            logging_q  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fail_cnt_1 <= '0;
            fail_cnt_2 <= '0;
            drop_cnt   <= '0;
            ovf        <= 1'b0;
            rd_vld     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.arm) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(HOLDOFF - 1);
                    end
                end
                HOLD: begin
                    if (!bus.arm) begin
                        state <= IDLE;
                    end else if (hold_cnt == '0) begin
                        state     <= ARMED;
                        logging_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                ARMED: begin
                    if (!bus.arm) begin
                        state     <= IDLE;
                        logging_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    logging_q <= 1'b0;
                end
            endcase

            wr_ptr <= wr_ptr + n_wr;
            rd_vld <= pop;
            if (pop) begin
                rd_ch   <= head[ADDR_W];
                rd_addr <= head[ADDR_W-1:0];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end

            if (want_1) fail_cnt_1 <= sat_add(fail_cnt_1, 2'd1);
            if (want_2) fail_cnt_2 <= sat_add(fail_cnt_2, 2'd1);
            if (n_drop != 2'd0) begin
                drop_cnt <= sat_add(drop_cnt, n_drop);
                ovf      <= 1'b1;
            end
        end
    end

    assign bus.rd_valid     = rd_vld;
    assign bus.rd_channel   = rd_ch;
    assign bus.rd_address   = rd_addr;
    assign bus.rd_empty     = (occ == '0);
    assign bus.fail_count_1 = fail_cnt_1;
    assign bus.fail_count_2 = fail_cnt_2;
    assign bus.drop_count   = drop_cnt;
    assign bus.overflow     = ovf;
    assign bus.logging      = logging_q;
endmodule
